// File: rtl/jno_condition_unit_if.sv
// Bus between decode/ALU/sequencer and the JNO condition stage.
// The condition unit sits on the slave side; decode and the sequencer use the master side.
interface jno_condition_unit_if #(
    parameter int ADDR_W = 8
);
    logic              alu_valid;
    logic [1:0]        alu_flags;
    logic              jno_req;
    logic [ADDR_W-1:0] jno_target;
    logic [1:0]        check;
    logic [ADDR_W-1:0] target_out;
    logic              busy;
    logic              done;
    logic              jno_drop;

    modport master (
        output alu_valid, alu_flags, jno_req, jno_target,
        input  check, target_out, busy, done, jno_drop
    );

    modport slave (
        input  alu_valid, alu_flags, jno_req, jno_target,
        output check, target_out, busy, done, jno_drop
    );
endinterface

// File: rtl/jno_condition_unit.sv
// JNO condition stage: latches ALU flags, evaluates jump-if-not-overflow and
// holds the registered check code for HOLD_CYCLES cycles before returning to idle.
module jno_condition_unit #(
    parameter int HOLD_CYCLES = 2,
    parameter int ADDR_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    jno_condition_unit_if.slave  bus
);
    // state | meaning
    // IDLE  | waiting for jno_req, check = 00
    // EVAL  | one cycle, decide take/fall-through from flags_q
    // HOLD  | check held constant until cnt reaches 0
    typedef enum logic [1:0] {IDLE = 2'd0, EVAL = 2'd1, HOLD = 2'd2} state_t;

    localparam int CNT_W    = $clog2(HOLD_CYCLES) + 1;
    localparam int HOLD_EFF = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_EFF - 1);

    state_t            state_q, state_d;
    logic [1:0]        flags_q;
    logic [1:0]        check_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] target_q;
    logic              drop_q;
    logic              busy_c;
    logic              done_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.jno_req) state_d = EVAL;
            EVAL:    state_d = HOLD;
            HOLD:    if (cnt_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_c = (state_q != IDLE);
        done_c = (state_q == HOLD) && (cnt_q == '0);
    end

    // Flags load in every state so a same-cycle alu_valid/jno_req pair is seen in EVAL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q  <= 2'b00;
            check_q  <= 2'b00;
            cnt_q    <= '0;
            target_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            if (bus.alu_valid) flags_q <= bus.alu_flags;
            drop_q <= bus.jno_req && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (bus.jno_req) target_q <= bus.jno_target;
                end
                EVAL: begin
                    check_q <= flags_q[1] ? 2'b01 : 2'b10;
                    cnt_q   <= CNT_LOAD;
                end
                HOLD: begin
                    if (cnt_q == '0) check_q <= 2'b00;
                    else             cnt_q   <= cnt_q - CNT_W'(1);
                end
                default: check_q <= 2'b00;
            endcase
        end
    end

    assign bus.check      = check_q;
    assign bus.target_out = target_q;
    assign bus.busy       = busy_c;
    assign bus.done       = done_c;
    assign bus.jno_drop   = drop_q;
endmodule

// File: tb/tb_jno_condition_unit.sv
// Directed bench for jno_condition_unit: one instance with HOLD_CYCLES=2 and one with 0.
module tb_jno_condition_unit;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    jno_condition_unit_if #(.ADDR_W(8)) bus  ();
    jno_condition_unit_if #(.ADDR_W(8)) bus0 ();

    jno_condition_unit #(.HOLD_CYCLES(2), .ADDR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    jno_condition_unit #(.HOLD_CYCLES(0), .ADDR_W(8)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [1:0] c, input logic [7:0] t,
                             input logic b, input logic d, input logic dr);
        chk({tag, ".check"},  16'(bus.check),      16'(c));
        chk({tag, ".target"}, 16'(bus.target_out), 16'(t));
        chk({tag, ".busy"},   16'(bus.busy),       16'(b));
        chk({tag, ".done"},   16'(bus.done),       16'(d));
        chk({tag, ".drop"},   16'(bus.jno_drop),   16'(dr));
    endtask

    initial begin
        rst = 1'b1;
        bus.alu_valid  = 1'b0; bus.alu_flags  = 2'b00; bus.jno_req  = 1'b0; bus.jno_target  = 8'h00;
        bus0.alu_valid = 1'b0; bus0.alu_flags = 2'b00; bus0.jno_req = 1'b0; bus0.jno_target = 8'h00;
        tick();
        tick();
        chk_state("reset", 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("reset.check0", 16'(bus0.check), 16'h0);
        rst = 1'b0;

        // 1: idle for 10 cycles
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_state("idle", 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
        end

        // 2: flags 00, take the jump
        bus.alu_valid = 1'b1; bus.alu_flags = 2'b00;
        tick();
        bus.alu_valid = 1'b0;
        bus.jno_req = 1'b1; bus.jno_target = 8'h3C;
        tick();
        bus.jno_req = 1'b0;
        chk_state("t2.eval",  2'b00, 8'h3C, 1'b1, 1'b0, 1'b0);
        tick();
        chk_state("t2.hold1", 2'b10, 8'h3C, 1'b1, 1'b0, 1'b0);
        tick();
        chk_state("t2.hold2", 2'b10, 8'h3C, 1'b1, 1'b1, 1'b0);
        tick();
        chk_state("t2.idle",  2'b00, 8'h3C, 1'b0, 1'b0, 1'b0);

        // 3: overflow set, fall through
        bus.alu_valid = 1'b1; bus.alu_flags = 2'b10;
        tick();
        bus.alu_valid = 1'b0;
        bus.jno_req = 1'b1; bus.jno_target = 8'h10;
        tick();
        bus.jno_req = 1'b0;
        chk_state("t3.eval",  2'b00, 8'h10, 1'b1, 1'b0, 1'b0);
        tick();
        chk_state("t3.hold1", 2'b01, 8'h10, 1'b1, 1'b0, 1'b0);
        tick();
        chk_state("t3.hold2", 2'b01, 8'h10, 1'b1, 1'b1, 1'b0);
        tick();
        chk_state("t3.idle",  2'b00, 8'h10, 1'b0, 1'b0, 1'b0);

        // 4: same-cycle flags+request, then flags change during EVAL
        bus.alu_valid = 1'b1; bus.alu_flags = 2'b00;
        tick();
        bus.alu_flags = 2'b10; bus.jno_req = 1'b1; bus.jno_target = 8'h55;
        tick();
        bus.alu_flags = 2'b00; bus.jno_req = 1'b0;
        tick();
        bus.alu_valid = 1'b0;
        chk_state("t4.hold1", 2'b01, 8'h55, 1'b1, 1'b0, 1'b0);
        tick();
        chk_state("t4.hold2", 2'b01, 8'h55, 1'b1, 1'b1, 1'b0);
        tick();
        chk_state("t4.idle",  2'b00, 8'h55, 1'b0, 1'b0, 1'b0);

        // 5: request while busy is dropped; request after return is accepted
        bus.jno_req = 1'b1; bus.jno_target = 8'hA5;
        tick();
        bus.jno_target = 8'h77;
        tick();
        bus.jno_req = 1'b0;
        chk_state("t5.hold1", 2'b10, 8'hA5, 1'b1, 1'b0, 1'b1);
        tick();
        chk_state("t5.hold2", 2'b10, 8'hA5, 1'b1, 1'b1, 1'b0);
        tick();
        chk_state("t5.idle",  2'b00, 8'hA5, 1'b0, 1'b0, 1'b0);
        bus.jno_req = 1'b1; bus.jno_target = 8'h42;
        tick();
        bus.jno_req = 1'b0;
        chk_state("t5.eval2",  2'b00, 8'h42, 1'b1, 1'b0, 1'b0);
        tick();
        chk_state("t5.hold2a", 2'b10, 8'h42, 1'b1, 1'b0, 1'b0);
        tick();
        chk_state("t5.hold2b", 2'b10, 8'h42, 1'b1, 1'b1, 1'b0);
        tick();
        chk_state("t5.idle2",  2'b00, 8'h42, 1'b0, 1'b0, 1'b0);

        // 6: async reset in HOLD clears check before the next edge
        bus.jno_req = 1'b1; bus.jno_target = 8'h99;
        tick();
        bus.jno_req = 1'b0;
        tick();
        chk_state("t6.hold1", 2'b10, 8'h99, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk_state("t6.rst", 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        chk_state("t6.rst_edge", 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk_state("t6.after", 2'b00, 8'h00, 1'b0, 1'b0, 1'b0);

        // 6b: HOLD_CYCLES=0 behaves as 1
        bus0.jno_req = 1'b1; bus0.jno_target = 8'h21;
        tick();
        bus0.jno_req = 1'b0;
        chk("h0.eval.busy",  16'(bus0.busy),  16'h1);
        chk("h0.eval.check", 16'(bus0.check), 16'h0);
        tick();
        chk("h0.hold.check",  16'(bus0.check),      16'h2);
        chk("h0.hold.done",   16'(bus0.done),       16'h1);
        chk("h0.hold.target", 16'(bus0.target_out), 16'h21);
        tick();
        chk("h0.idle.check", 16'(bus0.check), 16'h0);
        chk("h0.idle.busy",  16'(bus0.busy),  16'h0);
        chk("h0.idle.done",  16'(bus0.done),  16'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
